msrv32_trap_csr_unit: RTL and testbench

MSRV32_TRAP_CSR_UNIT -- requirements
Module: msrv32_trap_csr_unit

---
 rtl/msrv32_trap_csr_unit.sv | 204 ++++++++++++++++++++
 tb/tb_msrv32_trap_csr_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_trap_csr_unit.sv
// Machine-mode CSR file and trap support for the msrv32 core: CSR read/modify/write,
// trap entry/return bookkeeping, interrupt pending capture and 64-bit cycle/instret counters.
module msrv32_trap_csr_unit (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        ms_riscv32_mp_eirq_in,
  input  logic        ms_riscv32_mp_tirq_in,
  input  logic        ms_riscv32_mp_sirq_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic        csr_wr_en_in,
  input  logic [31:0] csr_wdata_in,
  output logic [31:0] csr_rdata_out,
  output logic        illegal_csr_out,
  input  logic        set_epc_in,
  input  logic        set_cause_in,
  input  logic        mie_clear_in,
  input  logic        mie_set_in,
  input  logic        instret_inc_in,
  input  logic        misaligned_exception_in,
  input  logic        i_or_e_in,
  input  logic [3:0]  cause_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] trap_addr_in,
  output logic        mie_out,
  output logic        meie_out,
  output logic        mtie_out,
  output logic        msie_out,
  output logic        meip_out,
  output logic        mtip_out,
  output logic        msip_out,
  output logic [31:0] trap_address_out,
  output logic [31:0] epc_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  // RS/RC with a zero operand are pure reads; op[1:0]=00 never writes.
  function automatic logic csr_has_effect(input logic [2:0] op, input logic [31:0] wd);
    csr_has_effect = (op[1:0] == 2'b01) || ((op[1:0] != 2'b00) && (wd != 32'd0));
  endfunction

  function automatic logic [31:0] csr_apply(input logic [2:0] op, input logic [31:0] old,
                                            input logic [31:0] wd);
    case (op[1:0])
      2'b01:   csr_apply = wd;
      2'b10:   csr_apply = old | wd;
      2'b11:   csr_apply = old & ~wd;
      default: csr_apply = old;
    endcase
  endfunction

  logic        mstatus_mie_q, mstatus_mie_d, mpie_q, mpie_d;
  logic        meie_q, meie_d, mtie_q, mtie_d, msie_q, msie_d;
  logic        meip_q, mtip_q, msip_q;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic        impl, has_eff, wr_ok;
  logic [31:0] rdata, wval;

  // Read mux: old value of the addressed CSR and whether the address exists.
  always_comb begin
    rdata = 32'd0;
    impl  = 1'b1;
    case (csr_addr_in)
      A_MSTATUS:   rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      A_MISA:      rdata = 32'h4000_0100;
      A_MIE:       rdata = {20'd0, meie_q, 3'd0, mtie_q, 3'd0, msie_q, 3'd0};
      A_MTVEC:     rdata = mtvec_q;
      A_MSCRATCH:  rdata = mscratch_q;
      A_MEPC:      rdata = mepc_q;
      A_MCAUSE:    rdata = mcause_q;
      A_MTVAL:     rdata = mtval_q;
      A_MIP:       rdata = {20'd0, meip_q, 3'd0, mtip_q, 3'd0, msip_q, 3'd0};
      A_MCYCLE:    rdata = mcycle_q[31:0];
      A_MCYCLEH:   rdata = mcycle_q[63:32];
      A_MINSTRET:  rdata = minstret_q[31:0];
      A_MINSTRETH: rdata = minstret_q[63:32];
      default:     impl  = 1'b0;
    endcase
  end

  assign has_eff         = csr_has_effect(csr_op_in, csr_wdata_in);
  assign illegal_csr_out = csr_wr_en_in &&
                           (!impl || ((csr_addr_in[11:10] == 2'b11) && has_eff));
  assign wr_ok           = csr_wr_en_in && !illegal_csr_out && has_eff;
  assign wval            = csr_apply(csr_op_in, rdata, csr_wdata_in);
  assign csr_rdata_out   = rdata;

  // Next-state: trap controls override a same-cycle software write to the same CSR.
  always_comb begin
    mstatus_mie_d = mstatus_mie_q;
    mpie_d        = mpie_q;
    meie_d        = meie_q;
    mtie_d        = mtie_q;
    msie_d        = msie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    mcycle_d      = mcycle_q + 64'd1;
    minstret_d    = minstret_q + {63'd0, instret_inc_in};

    if (mie_clear_in) begin
      mpie_d        = mstatus_mie_q;
      mstatus_mie_d = 1'b0;
    end else if (mie_set_in) begin
      mstatus_mie_d = mpie_q;
      mpie_d        = 1'b1;
    end else if (wr_ok && csr_addr_in == A_MSTATUS) begin
      mstatus_mie_d = wval[3];
      mpie_d        = wval[7];
    end

    if (wr_ok) begin
      case (csr_addr_in)
        A_MIE:       {meie_d, mtie_d, msie_d} = {wval[11], wval[7], wval[3]};
        A_MTVEC:     mtvec_d = {wval[31:2], 1'b0, wval[0]};
        A_MSCRATCH:  mscratch_d = wval;
        A_MEPC:      mepc_d = {wval[31:2], 2'b00};
        A_MCAUSE:    mcause_d = wval;
        A_MTVAL:     mtval_d = wval;
        A_MCYCLE:    mcycle_d[31:0] = wval;
        A_MCYCLEH:   mcycle_d[63:32] = wval;
        A_MINSTRET:  minstret_d[31:0] = wval;
        A_MINSTRETH: minstret_d[63:32] = wval;
        default:     ;
      endcase
    end

    if (set_epc_in) mepc_d = {pc_in[31:2], 2'b00};
    if (set_cause_in) begin
      mcause_d = {i_or_e_in, 27'd0, cause_in};
      mtval_d  = misaligned_exception_in ? trap_addr_in : 32'd0;
    end
  end

  // State register; reset aborts any update pending in the current cycle.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      mstatus_mie_q <= 1'b0;
      mpie_q        <= 1'b0;
      meie_q        <= 1'b0;
      mtie_q        <= 1'b0;
      msie_q        <= 1'b0;
      meip_q        <= 1'b0;
      mtip_q        <= 1'b0;
      msip_q        <= 1'b0;
      mtvec_q       <= 32'd0;
      mscratch_q    <= 32'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mtval_q       <= 32'd0;
      mcycle_q      <= 64'd0;
      minstret_q    <= 64'd0;
    end else begin
      mstatus_mie_q <= mstatus_mie_d;
      mpie_q        <= mpie_d;
      meie_q        <= meie_d;
      mtie_q        <= mtie_d;
      msie_q        <= msie_d;
      meip_q        <= ms_riscv32_mp_eirq_in;
      mtip_q        <= ms_riscv32_mp_tirq_in;
      msip_q        <= ms_riscv32_mp_sirq_in;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

  // Vectored mode only applies to interrupts: base + 4*cause.
  assign trap_address_out = (mtvec_q[0] && mcause_q[31]) ?
                            ({mtvec_q[31:2], 2'b00} + {26'd0, mcause_q[3:0], 2'b00}) :
                            {mtvec_q[31:2], 2'b00};

  assign mie_out  = mstatus_mie_q;
  assign meie_out = meie_q;
  assign mtie_out = mtie_q;
  assign msie_out = msie_q;
  assign meip_out = meip_q;
  assign mtip_out = mtip_q;
  assign msip_out = msip_q;
  assign epc_out  = mepc_q;

endmodule

// File: tb/tb_msrv32_trap_csr_unit.sv
module tb_msrv32_trap_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eirq, tirq, sirq;
  logic [11:0] addr;
  logic [2:0]  op;
  logic        wr_en;
  logic [31:0] wdata, rdata;
  logic        illegal;
  logic        set_epc, set_cause, mclr, mset, iinc, mis, ioe;
  logic [3:0]  cause;
  logic [31:0] pc, taddr;
  logic        mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o;
  logic [31:0] trap_address, epc;

  always #5 clk = ~clk;

  msrv32_trap_csr_unit dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
    .ms_riscv32_mp_eirq_in(eirq), .ms_riscv32_mp_tirq_in(tirq), .ms_riscv32_mp_sirq_in(sirq),
    .csr_addr_in(addr), .csr_op_in(op), .csr_wr_en_in(wr_en), .csr_wdata_in(wdata),
    .csr_rdata_out(rdata), .illegal_csr_out(illegal),
    .set_epc_in(set_epc), .set_cause_in(set_cause), .mie_clear_in(mclr), .mie_set_in(mset),
    .instret_inc_in(iinc), .misaligned_exception_in(mis), .i_or_e_in(ioe),
    .cause_in(cause), .pc_in(pc), .trap_addr_in(taddr),
    .mie_out(mie_o), .meie_out(meie_o), .mtie_out(mtie_o), .msie_out(msie_o),
    .meip_out(meip_o), .mtip_out(mtip_o), .msip_out(msip_o),
    .trap_address_out(trap_address), .epc_out(epc)
  );

  typedef struct {
    logic [11:0] addr; logic [2:0] op; logic wr; logic [31:0] wdata;
    logic set_epc, set_cause, mclr, mset, iinc, mis, ioe;
    logic [3:0] cause; logic [31:0] pc, taddr;
    logic eirq, tirq, sirq;
  } stim_t;

  typedef struct {
    logic [31:0] rdata; logic illegal; logic [31:0] taddr; logic [31:0] epc; logic [6:0] flags;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  stim_t prev;
  bit    have_prev = 0;

  // Reference machine state, kept as whole architectural values.
  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
  logic [63:0] m_cyc, m_ins;

  logic [11:0] alist [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                              12'h7C0, 12'hF11, 12'hC00, 12'h000};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_ie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_effect(input stim_t s);
    return (s.op[1:0] == 2'b01) || (s.op[1:0] != 2'b00 && s.wdata != 0);
  endfunction

  function automatic bit m_illegal(input stim_t s);
    return s.wr && (!m_impl(s.addr) || (s.addr[11:10] == 2'b11 && m_effect(s)));
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_ie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
  endtask

  // Effect of one rising edge with stimulus s applied.
  task automatic model_step(input stim_t s);
    logic [31:0] old, nv;
    logic [63:0] n_cyc, n_ins;
    bit w;
    old = m_read(s.addr);
    w = s.wr && !m_illegal(s) && m_effect(s);
    nv = (s.op[1:0] == 2'b01) ? s.wdata : (s.op[1:0] == 2'b10) ? (old | s.wdata) : (old & ~s.wdata);
    n_cyc = m_cyc + 64'd1;
    n_ins = m_ins + 64'(s.iinc);
    if (w && s.addr == 12'hB00) n_cyc[31:0] = nv;
    if (w && s.addr == 12'hB80) n_cyc[63:32] = nv;
    if (w && s.addr == 12'hB02) n_ins[31:0] = nv;
    if (w && s.addr == 12'hB82) n_ins[63:32] = nv;
    m_cyc = n_cyc; m_ins = n_ins;
    if (s.mclr) begin m_mpie = m_mie; m_mie = 0; end
    else if (s.mset) begin m_mie = m_mpie; m_mpie = 1; end
    else if (w && s.addr == 12'h300) begin m_mie = nv[3]; m_mpie = nv[7]; end
    if (w && s.addr == 12'h304) m_ie = nv & 32'h888;
    if (w && s.addr == 12'h305) m_mtvec = nv & ~32'h2;
    if (w && s.addr == 12'h340) m_mscratch = nv;
    if (s.set_epc) m_mepc = {s.pc[31:2], 2'b00};
    else if (w && s.addr == 12'h341) m_mepc = nv & ~32'h3;
    if (s.set_cause) begin
      m_mcause = {s.ioe, 27'd0, s.cause};
      m_mtval  = s.mis ? s.taddr : 32'd0;
    end else begin
      if (w && s.addr == 12'h342) m_mcause = nv;
      if (w && s.addr == 12'h343) m_mtval = nv;
    end
    m_mip = (32'(s.eirq) << 11) | (32'(s.tirq) << 7) | (32'(s.sirq) << 3);
  endtask

  task automatic push_exp(input stim_t s);
    exp_t e;
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    e.rdata = m_read(s.addr);
    e.illegal = m_illegal(s);
    e.taddr = (m_mtvec[0] && m_mcause[31]) ? base + 32'd4 * 32'(m_mcause[3:0]) : base;
    e.epc = m_mepc;
    e.flags = {m_mie, m_ie[11], m_ie[7], m_ie[3], m_mip[11], m_mip[7], m_mip[3]};
    q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    addr = s.addr; op = s.op; wr_en = s.wr; wdata = s.wdata;
    set_epc = s.set_epc; set_cause = s.set_cause; mclr = s.mclr; mset = s.mset;
    iinc = s.iinc; mis = s.mis; ioe = s.ioe; cause = s.cause; pc = s.pc; taddr = s.taddr;
    eirq = s.eirq; tirq = s.tirq; sirq = s.sirq;
  endtask

  function automatic stim_t idle(input logic [11:0] a);
    stim_t s;
    s = '{addr: a, op: 3'd0, wr: 1'b0, wdata: 32'd0, set_epc: 1'b0, set_cause: 1'b0,
          mclr: 1'b0, mset: 1'b0, iinc: 1'b0, mis: 1'b0, ioe: 1'b0, cause: 4'd0,
          pc: 32'd0, taddr: 32'd0, eirq: 1'b0, tirq: 1'b0, sirq: 1'b0};
    return s;
  endfunction

  function automatic stim_t wr_stim(input logic [11:0] a, input logic [2:0] o, input logic [31:0] d);
    stim_t s;
    s = idle(a); s.wr = 1'b1; s.op = o; s.wdata = d;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.addr = alist[$urandom_range(16, 0)];
    s.op = 3'($urandom);
    s.wr = 1'($urandom);
    case ($urandom_range(3, 0))
      0: s.wdata = 32'd0;
      1: s.wdata = 32'($urandom_range(31, 0));
      2: s.wdata = 32'hFFFF_FFFF;
      default: s.wdata = $urandom;
    endcase
    s.set_epc = ($urandom_range(7, 0) == 0);
    s.set_cause = ($urandom_range(7, 0) == 0);
    s.mclr = ($urandom_range(7, 0) == 0);
    s.mset = ($urandom_range(7, 0) == 0);
    s.iinc = 1'($urandom);
    s.mis = 1'($urandom);
    s.ioe = 1'($urandom);
    s.cause = 4'($urandom);
    s.pc = $urandom;
    s.taddr = $urandom;
    s.eirq = 1'($urandom); s.tirq = 1'($urandom); s.sirq = 1'($urandom);
    return s;
  endfunction

  // One clock: commit the previous stimulus in the model, apply the next one.
  task automatic cycle(input stim_t s);
    @(posedge clk); #1;
    if (have_prev) model_step(prev);
    drive(s);
    prev = s;
    have_prev = 1;
    push_exp(s);
  endtask

  // Assert reset between edges, check the reset view, release before the next edge.
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    have_prev = 0;
    drive(idle(12'h300));
    model_reset();
    push_exp(idle(12'h300));
    @(negedge clk); #1;
    rst_n = 1'b1;
    prev = idle(12'h300);
    have_prev = 1;
  endtask

  // Monitor: compare the DUT view against the queued expectation, mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("rdata", rdata, e.rdata);
      cmp("illegal", 32'(illegal), 32'(e.illegal));
      cmp("trap_address", trap_address, e.taddr);
      cmp("epc", epc, e.epc);
      cmp("flags", 32'({mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o}), 32'(e.flags));
    end
  end

  initial begin
    stim_t s;
    drive(idle(12'h300));
    do_reset();
    cmp("reset_mstatus", rdata, 32'h0000_1800);

    // Vectored interrupt target
    cycle(wr_stim(12'h305, 3'b001, 32'h0000_0101));
    s = idle(12'h342); s.set_cause = 1; s.ioe = 1; s.cause = 4'd7;
    cycle(s);
    cycle(idle(12'h342)); #1;
    cmp("mcause_irq", rdata, 32'h8000_0007);
    cmp("vector_target", trap_address, 32'h0000_011C);

    // Trap entry / mret stacking of MIE
    cycle(wr_stim(12'h300, 3'b001, 32'h0000_0008));
    s = idle(12'h300); s.mclr = 1; cycle(s);
    cycle(idle(12'h300)); #1;
    cmp("mie_after_clear", 32'(mie_o), 32'd0);
    cmp("mstatus_after_clear", rdata, 32'h0000_1880);
    s = idle(12'h300); s.mset = 1; cycle(s);
    cycle(idle(12'h300)); #1;
    cmp("mstatus_after_mret", rdata, 32'h0000_1888);

    // Misaligned trap: mepc alignment and mtval capture
    s = idle(12'h341); s.set_epc = 1; s.pc = 32'h0000_0206;
    s.set_cause = 1; s.mis = 1; s.taddr = 32'h0000_1003; s.cause = 4'd0;
    cycle(s);
    cycle(idle(12'h341)); #1;
    cmp("mepc", epc, 32'h0000_0204);
    cycle(idle(12'h343)); #1;
    cmp("mtval", rdata, 32'h0000_1003);

    // minstret carry into the high half
    cycle(wr_stim(12'hB02, 3'b001, 32'hFFFF_FFFF));
    cycle(wr_stim(12'hB82, 3'b001, 32'h0000_0000));
    s = idle(12'hB02); s.iinc = 1; cycle(s);
    cycle(idle(12'hB02)); #1;
    cmp("minstret_lo", rdata, 32'd0);
    cycle(idle(12'hB82)); #1;
    cmp("minstret_hi", rdata, 32'd1);

    // mip capture latency and write immunity
    s = idle(12'h344); s.tirq = 1; cycle(s);
    cycle(idle(12'h344)); #1;
    cmp("mtip_latency", 32'(mtip_o), 32'd1);
    s = wr_stim(12'h344, 3'b001, 32'd0); s.tirq = 1; cycle(s);
    s = idle(12'h344); s.tirq = 1; cycle(s); #1;
    cmp("mip_write_ignored", rdata, 32'h0000_0080);

    // Illegal accesses
    cycle(wr_stim(12'h7C0, 3'b001, 32'h55)); #1;
    cmp("illegal_7c0", 32'(illegal), 32'd1);
    cycle(wr_stim(12'hF11, 3'b001, 32'h1)); #1;
    cmp("illegal_f11", 32'(illegal), 32'd1);

    for (int i = 0; i < 400; i++) cycle(rand_stim());

    // Reset in the middle of a pending write must abort it
    cycle(wr_stim(12'h340, 3'b001, 32'hDEAD_BEEF));
    do_reset();
    cycle(idle(12'h340)); #1;
    cmp("mscratch_aborted", rdata, 32'd0);
    cycle(idle(12'hB00)); #1;
    cmp("mcycle_after_reset", rdata, 32'd2);

    for (int i = 0; i < 300; i++) cycle(rand_stim());

    repeat (2) @(negedge clk);
    #1;
    cmp("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
